// File: rtl/fpga_rst_seq_pkg.sv
// Shared types for the board reset sequencer: one-hot FSM encoding and
// reset-cause bit positions.
package fpga_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'b001,
    ST_STRETCH   = 3'b010,
    ST_RUN       = 3'b100
  } rst_state_e;

  // The RUN bit of the one-hot state is the reset output itself.
  localparam int ST_RUN_BIT = 2;

  localparam int CAUSE_W    = 3;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_BTN  = 1;
  localparam int CAUSE_LOCK = 2;

endpackage

// File: rtl/fpga_debounce.sv
// Synchroniser chain followed by a consecutive-sample debounce counter.
// The output flips only after DEBOUNCE_CYCLES consecutive contrary samples.
module fpga_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 125000,
  parameter logic RST_LEVEL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic                   w_sync_s;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign w_sync_d[gi] = d_i;
      end else begin : g_chain
        assign w_sync_d[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= {SYNC_STAGES{RST_LEVEL}};
    end else begin
      r_sync <= w_sync_d;
    end
  end

  assign w_sync_s = r_sync[SYNC_STAGES-1];

  // Any sample matching the accepted level restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_stable <= RST_LEVEL;
    end else if (w_sync_s == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt    <= '0;
      r_stable <= w_sync_s;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign q_o = r_stable;

endmodule

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: debounced button plus synchronised PLL lock drive a
// stretched, glitch-free active-low SoC reset. Optional FPGA_RST_SEQ_CAUSE_EN.
module fpga_rst_seq
  import fpga_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int STRETCH_CYCLES  = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_i,
  input  logic               locked_i,
  output logic               rst_no,
`ifdef FPGA_RST_SEQ_CAUSE_EN
  output logic [CAUSE_W-1:0] rst_cause_o,
`endif
  output logic               busy_o
);

  localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SCW-1:0] STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] w_lock_d;
  logic                   w_locked_s;
  logic                   w_btn_stable;
  logic                   w_release;
  logic                   w_abort;
  rst_state_e             r_state;
  rst_state_e             w_state_next;
  logic [SCW-1:0]         r_cnt;
  logic [SCW-1:0]         w_cnt_next;

  fpga_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_LEVEL       (1'b1)
  ) u_btn_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (w_btn_stable)
  );

  // Lock is deliberately not debounced: a lock drop must act immediately.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_lock_sync
      if (gi == 0) begin : g_first
        assign w_lock_d[gi] = locked_i;
      end else begin : g_chain
        assign w_lock_d[gi] = r_lock_sync[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= w_lock_d;
    end
  end

  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
  assign w_release  = w_locked_s && !w_btn_stable;
  assign w_abort    = !w_release && ((r_state == ST_STRETCH) || (r_state == ST_RUN));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Abort is tested before stretch completion so it wins a same-cycle tie.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_release) w_state_next = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (w_abort) begin
          w_state_next = ST_WAIT_LOCK;
        end else if (r_cnt == STRETCH_LAST) begin
          w_state_next = ST_RUN;
        end else begin
          w_cnt_next = r_cnt + SCW'(1);
        end
      end
      ST_RUN: begin
        if (w_abort) w_state_next = ST_WAIT_LOCK;
      end
      default: w_state_next = ST_WAIT_LOCK;
    endcase
  end

  always_comb begin
    rst_no = r_state[ST_RUN_BIT];
    busy_o = ~r_state[ST_RUN_BIT];
  end

`ifdef FPGA_RST_SEQ_CAUSE_EN
  localparam logic [CAUSE_W-1:0] CAUSE_POR_V  = CAUSE_W'(1) << CAUSE_POR;
  localparam logic [CAUSE_W-1:0] CAUSE_BTN_V  = CAUSE_W'(1) << CAUSE_BTN;
  localparam logic [CAUSE_W-1:0] CAUSE_LOCK_V = CAUSE_W'(1) << CAUSE_LOCK;

  logic [CAUSE_W-1:0] r_cause;

  // Button is reported when it coincides with a lock drop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cause <= CAUSE_POR_V;
    end else if (w_abort) begin
      r_cause <= w_btn_stable ? CAUSE_BTN_V : CAUSE_LOCK_V;
    end
  end

  assign rst_cause_o = r_cause;
`endif

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq: vector table, hand-timed latency
// sequences, and randomized stimulus against a run-length reference model.
module tb_fpga_rst_seq;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int STR  = 16;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic locked_i = 1'b0;
  logic rst_no;
  logic busy_o;
`ifdef FPGA_RST_SEQ_CAUSE_EN
  logic [2:0] rst_cause_o;
`endif

  int checks = 0;
  int errors = 0;

  fpga_rst_seq #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .STRETCH_CYCLES  (STR)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .btn_i    (btn_i),
    .locked_i (locked_i),
    .rst_no   (rst_no),
`ifdef FPGA_RST_SEQ_CAUSE_EN
    .rst_cause_o (rst_cause_o),
`endif
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: delayed samples, a sliding window for the debounce rule
  // and a run length of "release conditions met" for the stretch rule.
  bit       m_valid = 0;
  bit       m_btn_pipe [SYNC];
  bit       m_lock_pipe[SYNC];
  bit       m_hist[$];
  bit       m_stable;
  bit       m_prev_cond;
  int       m_run;
  bit       m_rstn;
  bit [2:0] m_cause;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0b required=%0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit cond_now;
    bit all_diff;
    if (rst_i) begin
      for (int k = 0; k < SYNC; k++) begin
        m_btn_pipe[k]  = 1'b1;
        m_lock_pipe[k] = 1'b0;
      end
      m_hist.delete();
      m_stable    = 1'b1;
      m_prev_cond = 1'b0;
      m_run       = 0;
      m_rstn      = 1'b0;
      m_cause     = 3'b001;
      m_valid     = 1'b1;
      return;
    end
    cond_now = m_lock_pipe[SYNC-1] && !m_stable;
    if (m_prev_cond && !cond_now) m_cause = m_stable ? 3'b010 : 3'b100;
    m_prev_cond = cond_now;
    if (!cond_now) m_run = 0;
    else if (m_run < STR + 1) m_run = m_run + 1;
    m_rstn = (m_run >= STR + 1);
    m_hist.push_back(m_btn_pipe[SYNC-1]);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] == m_stable) all_diff = 1'b0;
    if (all_diff) m_stable = !m_stable;
    for (int k = SYNC - 1; k > 0; k--) begin
      m_btn_pipe[k]  = m_btn_pipe[k-1];
      m_lock_pipe[k] = m_lock_pipe[k-1];
    end
    m_btn_pipe[0]  = btn_i;
    m_lock_pipe[0] = locked_i;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      check("model_rst_no", {2'b0, rst_no}, {2'b0, m_rstn});
      check("model_busy", {2'b0, busy_o}, {2'b0, !m_rstn});
`ifdef FPGA_RST_SEQ_CAUSE_EN
      check("model_cause", rst_cause_o, m_cause);
`endif
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_rstn(input string name, input logic exp);
    check(name, {2'b0, rst_no}, {2'b0, exp});
    check({name, "_busy"}, {2'b0, busy_o}, {2'b0, !exp});
  endtask

  task automatic expect_cause(input string name, input logic [2:0] exp);
`ifdef FPGA_RST_SEQ_CAUSE_EN
    check(name, rst_cause_o, exp);
`endif
  endtask

  typedef struct {
    logic rst;
    logic btn;
    logic lock;
    int   cycles;
    bit   every;
    logic exp_rstn;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0,  4, 1'b1, 1'b0};  // power-up
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 12, 1'b1, 1'b0};  // no lock yet
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 19, 1'b0, 1'b1};  // release after 19 edges
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b1};  // bounce rejected
    vecs[5]  = '{1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1,  1, 1'b1, 1'b0};  // rst_i mid-RUN
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 27, 1'b0, 1'b1};  // debounce + stretch
    vecs[10] = '{1'b1, 1'b1, 1'b1,  4, 1'b1, 1'b0};  // button held at power-up
    vecs[11] = '{1'b0, 1'b1, 1'b1, 40, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 26, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b1};

    #2;
    foreach (vecs[v]) begin
      rst_i    = vecs[v].rst;
      btn_i    = vecs[v].btn;
      locked_i = vecs[v].lock;
      for (int c = 1; c <= vecs[v].cycles; c++) begin
        tick();
        if (vecs[v].every || c == vecs[v].cycles) begin
          expect_rstn($sformatf("vec%0d_c%0d", v, c), vecs[v].exp_rstn);
          if (vecs[v].rst) expect_cause($sformatf("vec%0d_cause", v), 3'b001);
        end
      end
    end

    // Exact lock-to-release latency from WAIT_LOCK.
    locked_i = 1'b0;
    tick_n(3);
    expect_rstn("lockloss_3", 1'b0);
    expect_cause("lockloss_cause", 3'b100);
    tick_n(6);
    locked_i = 1'b1;
    tick_n(18);
    expect_rstn("relock_18", 1'b0);
    tick();
    expect_rstn("relock_19", 1'b1);

    // Button press from RUN, then release with a full stretch.
    btn_i = 1'b1;
    tick_n(10);
    expect_rstn("press_10", 1'b1);
    tick();
    expect_rstn("press_11", 1'b0);
    expect_cause("press_cause", 3'b010);
    tick_n(4);
    btn_i = 1'b0;
    tick_n(26);
    expect_rstn("unpress_26", 1'b0);
    tick();
    expect_rstn("unpress_27", 1'b1);

    // Lock lost at stretch count 10 after a button reset.
    btn_i = 1'b1;
    tick_n(14);
    btn_i = 1'b0;
    tick_n(21);
    expect_rstn("stretch10", 1'b0);
    expect_cause("stretch10_cause", 3'b010);
    locked_i = 1'b0;
    tick_n(2);
    expect_cause("drop_2_cause", 3'b010);
    tick();
    expect_cause("drop_3_cause", 3'b100);
    expect_rstn("drop_3", 1'b0);
    tick_n(6);
    locked_i = 1'b1;
    tick_n(18);
    expect_rstn("restretch_18", 1'b0);
    tick();
    expect_rstn("restretch_19", 1'b1);
    expect_cause("restretch_cause", 3'b100);

    // Debounced press and lock loss land on the same edge.
    btn_i = 1'b1;
    tick_n(8);
    locked_i = 1'b0;
    tick_n(2);
    expect_rstn("simul_10", 1'b1);
    tick();
    expect_rstn("simul_11", 1'b0);
    expect_cause("simul_cause", 3'b010);
    btn_i    = 1'b0;
    locked_i = 1'b1;
    tick_n(30);
    expect_rstn("simul_recover", 1'b1);

    // Randomized segments checked every cycle against the model.
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      len      = int'($urandom_range(1, 40));
      rst_i    = ($urandom_range(0, 30) == 0);
      if (rst_i) len = int'($urandom_range(1, 3));
      btn_i    = ($urandom_range(0, 3) == 0);
      locked_i = ($urandom_range(0, 4) != 0);
      tick_n(len);
    end
    rst_i = 1'b0;
    tick_n(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
